// File: rtl/pio_cmd_sequencer.sv
// PIO command sequencer: latches a software instruction on a rising enable edge and
// runs it as a coprocessor-memory byte access or an accelerator start/done handshake.
module pio_cmd_sequencer #(
   parameter int ADDR_W      = 17,
   parameter int RD_LAT      = 2,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              enable,
   input  logic [28:0]       instruct,
   input  logic              mem_sel,
   output logic [3:0]        flags,
   output logic [7:0]        data_out,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   output logic              mem_re,
   output logic              mem_bank,
   input  logic [7:0]        mem_rdata,
   output logic              acc_start,
   output logic [3:0]        acc_op,
   output logic [7:0]        acc_param,
   input  logic              acc_done
);

   localparam int CNT_MAX = (TIMEOUT_CYC > RD_LAT) ? TIMEOUT_CYC : RD_LAT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_MEM_RD,
      S_MEM_WR,
      S_ACC_WAIT,
      S_DONE
   } state_t;

   state_t              state_q;
   logic                enable_q;
   logic [28:0]         instr_q;
   logic                sel_q;
   logic [CNT_W-1:0]    cnt_q;
   logic                done_q;
   logic                error_q;
   logic                busy_q;
   logic                timeout_q;
   logic [7:0]          data_out_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [7:0]          mem_wdata_q;
   logic                mem_we_q;
   logic                mem_re_q;
   logic                mem_bank_q;
   logic                acc_start_q;
   logic [3:0]          acc_op_q;
   logic [7:0]          acc_param_q;
   logic                accept;

   // Only IDLE and DONE listen to software; a command in flight cannot be disturbed.
   assign accept = enable && !enable_q && (state_q == S_IDLE || state_q == S_DONE);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q     <= S_IDLE;
         enable_q    <= 1'b1;
         instr_q     <= '0;
         sel_q       <= 1'b0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         busy_q      <= 1'b0;
         timeout_q   <= 1'b0;
         data_out_q  <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         mem_bank_q  <= 1'b0;
         acc_start_q <= 1'b0;
         acc_op_q    <= '0;
         acc_param_q <= '0;
      end else begin
         enable_q    <= enable;
         mem_we_q    <= 1'b0;
         mem_re_q    <= 1'b0;
         acc_start_q <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               if (accept) begin
                  instr_q   <= instruct;
                  sel_q     <= mem_sel;
                  done_q    <= 1'b0;
                  error_q   <= 1'b0;
                  timeout_q <= 1'b0;
                  busy_q    <= 1'b1;
                  state_q   <= S_DECODE;
               end
            end
            S_DECODE: begin
               cnt_q <= '0;
               case (instr_q[3:0])
                  4'h1: begin
                     mem_re_q   <= 1'b1;
                     mem_addr_q <= ADDR_W'(instr_q[20:4]);
                     mem_bank_q <= sel_q;
                     state_q    <= S_MEM_RD;
                  end
                  4'h2: begin
                     mem_we_q    <= 1'b1;
                     mem_addr_q  <= ADDR_W'(instr_q[20:4]);
                     mem_wdata_q <= instr_q[28:21];
                     mem_bank_q  <= sel_q;
                     state_q     <= S_MEM_WR;
                  end
                  4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                     acc_start_q <= 1'b1;
                     acc_op_q    <= instr_q[3:0];
                     acc_param_q <= instr_q[28:21];
                     state_q     <= S_ACC_WAIT;
                  end
                  4'h0: begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_DONE;
                  end
                  4'hF: begin
                     data_out_q <= '0;
                     done_q     <= 1'b1;
                     busy_q     <= 1'b0;
                     state_q    <= S_DONE;
                  end
                  default: begin
                     error_q <= 1'b1;
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= S_DONE;
                  end
               endcase
            end
            S_MEM_WR: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_DONE;
            end
            S_MEM_RD: begin
               // cnt_q counts cycles since the read strobe; data is valid at RD_LAT.
               if (cnt_q == CNT_W'(RD_LAT)) begin
                  data_out_q <= mem_rdata;
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_ACC_WAIT: begin
               if (acc_done) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_DONE;
               end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                  done_q    <= 1'b1;
                  error_q   <= 1'b1;
                  timeout_q <= 1'b1;
                  busy_q    <= 1'b0;
                  state_q   <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign flags     = {timeout_q, busy_q, error_q, done_q};
   assign data_out  = data_out_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_we    = mem_we_q;
   assign mem_re    = mem_re_q;
   assign mem_bank  = mem_bank_q;
   assign acc_start = acc_start_q;
   assign acc_op    = acc_op_q;
   assign acc_param = acc_param_q;

endmodule
